// File: rtl/if_stage.sv
//==============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage with PC, IF/ID pipeline register and
//               a saturating frozen-cycle counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [31:0] c_PC_STEP = 32'd4;

  logic [31:0]      r_pc;
  logic [31:0]      r_if_id_pc;
  logic [31:0]      r_if_id_instr;
  logic             r_if_id_valid;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_branch_target;
  logic             w_cnt_sat;

  logic [31:0]      w_pc_nxt;
  logic [31:0]      w_if_id_pc_nxt;
  logic [31:0]      w_if_id_instr_nxt;
  logic             w_if_id_valid_nxt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;

  assign w_pc_plus4      = r_pc + c_PC_STEP;
  assign w_branch_target = branch_addr & 32'hFFFF_FFFC;
  assign w_cnt_sat       = &r_stall_cnt;

  // Branch outranks freeze: the stalled instruction is squashed, so the
  // cycle is not counted as a stall.
  always_comb begin
    w_pc_nxt          = r_pc;
    w_if_id_pc_nxt    = r_if_id_pc;
    w_if_id_instr_nxt = r_if_id_instr;
    w_if_id_valid_nxt = r_if_id_valid;
    w_stall_cnt_nxt   = r_stall_cnt;
    if (branch_taken) begin
      w_pc_nxt          = w_branch_target;
      w_if_id_pc_nxt    = 32'h0;
      w_if_id_instr_nxt = 32'h0;
      w_if_id_valid_nxt = 1'b0;
    end else if (freeze) begin
      if (!w_cnt_sat) begin
        w_stall_cnt_nxt = r_stall_cnt + 1'b1;
      end
    end else begin
      w_pc_nxt          = w_pc_plus4;
      w_if_id_pc_nxt    = w_pc_plus4;
      w_if_id_instr_nxt = imem_rdata;
      w_if_id_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_if_id_pc    <= 32'h0;
      r_if_id_instr <= 32'h0;
      r_if_id_valid <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_if_id_pc    <= w_if_id_pc_nxt;
      r_if_id_instr <= w_if_id_instr_nxt;
      r_if_id_valid <= w_if_id_valid_nxt;
      r_stall_cnt   <= w_stall_cnt_nxt;
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_valid = r_if_id_valid;
  assign stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//==============================================================================
// Module      : tb_if_stage
// Description : Directed and random checks of if_stage against a cycle model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_if_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;

  logic [31:0] imem_addr0, imem_rdata0, if_id_pc0, if_id_instr0;
  logic        if_id_valid0;
  logic [15:0] stall_cnt0;
  logic [31:0] imem_addr1, imem_rdata1, if_id_pc1, if_id_instr1;
  logic        if_id_valid1;
  logic [3:0]  stall_cnt1;

  // Instruction memory: the word at byte address A holds A>>2.
  assign imem_rdata0 = imem_addr0 >> 2;
  assign imem_rdata1 = imem_addr1 >> 2;

  if_stage u_dut0 (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
    .if_id_pc(if_id_pc0), .if_id_instr(if_id_instr0), .if_id_valid(if_id_valid0),
    .stall_cnt(stall_cnt0)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
    .if_id_pc(if_id_pc1), .if_id_instr(if_id_instr1), .if_id_valid(if_id_valid1),
    .stall_cnt(stall_cnt1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_pc    [2];
  logic [31:0] m_ipc   [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_valid [2];
  int          m_cnt   [2];
  logic [31:0] c_rst_pc  [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
  int          c_cnt_max [2] = '{65535, 15};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance the reference by one edge using the current inputs.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pc[i] = c_rst_pc[i]; m_ipc[i] = 0; m_instr[i] = 0; m_valid[i] = 0; m_cnt[i] = 0;
      end else if (branch_taken) begin
        m_pc[i] = {branch_addr[31:2], 2'b00};
        m_ipc[i] = 0; m_instr[i] = 0; m_valid[i] = 0;
      end else if (freeze) begin
        if (m_cnt[i] < c_cnt_max[i]) m_cnt[i] = m_cnt[i] + 1;
      end else begin
        m_instr[i] = m_pc[i] >> 2;
        m_pc[i]    = m_pc[i] + 32'd4;
        m_ipc[i]   = m_pc[i];
        m_valid[i] = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s d0.pc", tag),    imem_addr0,          m_pc[0]);
    chk($sformatf("%s d0.ipc", tag),   if_id_pc0,           m_ipc[0]);
    chk($sformatf("%s d0.instr", tag), if_id_instr0,        m_instr[0]);
    chk($sformatf("%s d0.valid", tag), {31'b0, if_id_valid0}, m_valid[0]);
    chk($sformatf("%s d0.cnt", tag),   {16'b0, stall_cnt0}, m_cnt[0]);
    chk($sformatf("%s d1.pc", tag),    imem_addr1,          m_pc[1]);
    chk($sformatf("%s d1.ipc", tag),   if_id_pc1,           m_ipc[1]);
    chk($sformatf("%s d1.instr", tag), if_id_instr1,        m_instr[1]);
    chk($sformatf("%s d1.valid", tag), {31'b0, if_id_valid1}, m_valid[1]);
    chk($sformatf("%s d1.cnt", tag),   {28'b0, stall_cnt1}, m_cnt[1]);
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 0; m_ipc[i] = 0; m_instr[i] = 0; m_valid[i] = 0; m_cnt[i] = 0;
    end

    // Reset for two cycles
    cyc("reset1");
    cyc("reset2");
    chk("reset pc0", imem_addr0, 32'h0);
    chk("reset pc1", imem_addr1, 32'hFFFF_FFF8);
    chk("reset valid0", {31'b0, if_id_valid0}, 32'd0);

    // Sequential fetch
    rst = 1'b0;
    cyc("fetch1");
    chk("fetch1 instr", if_id_instr0, 32'd0);
    chk("fetch1 ipc", if_id_pc0, 32'd4);
    chk("fetch1 valid", {31'b0, if_id_valid0}, 32'd1);
    chk("wrap1 pc", imem_addr1, 32'hFFFF_FFFC);
    cyc("fetch2");
    chk("fetch2 pc", imem_addr0, 32'd8);
    chk("fetch2 instr", if_id_instr0, 32'd1);
    chk("wrap2 pc", imem_addr1, 32'h0);

    // Freeze three cycles at pc=8
    freeze = 1'b1;
    repeat (3) cyc("freeze");
    chk("freeze pc", imem_addr0, 32'd8);
    chk("freeze instr", if_id_instr0, 32'd1);
    chk("freeze ipc", if_id_pc0, 32'd8);
    chk("freeze cnt", {16'b0, stall_cnt0}, 32'd3);
    freeze = 1'b0;
    cyc("resume");
    chk("resume instr", if_id_instr0, 32'd2);
    chk("resume pc", imem_addr0, 32'd12);

    // Branch with misaligned target
    branch_taken = 1'b1; branch_addr = 32'h0000_0103;
    cyc("branch");
    chk("branch pc", imem_addr0, 32'h100);
    chk("branch bubble", {31'b0, if_id_valid0}, 32'd0);
    branch_taken = 1'b0;
    cyc("branch_tgt");
    chk("target instr", if_id_instr0, 32'h40);
    chk("target ipc", if_id_pc0, 32'h104);

    // Branch together with freeze
    branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h200;
    cyc("br_frz");
    chk("br_frz pc", imem_addr0, 32'h200);
    chk("br_frz cnt", {16'b0, stall_cnt0}, 32'd3);
    branch_taken = 1'b0; freeze = 1'b0;
    cyc("post_br");

    // Reset asserted during a freeze
    freeze = 1'b1; rst = 1'b1;
    cyc("rst_frz");
    chk("rst_frz pc1", imem_addr1, 32'hFFFF_FFF8);
    chk("rst_frz cnt1", {28'b0, stall_cnt1}, 32'd0);
    chk("rst_frz instr1", if_id_instr1, 32'd0);

    // Saturation of the narrow counter
    rst = 1'b0;
    repeat (20) cyc("sat");
    chk("sat cnt1", {28'b0, stall_cnt1}, 32'd15);
    chk("sat cnt0", {16'b0, stall_cnt0}, 32'd20);
    freeze = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(39) == 0);
      branch_taken = ($urandom_range(7) == 0);
      freeze       = ($urandom_range(3) == 0);
      branch_addr  = $urandom();
      cyc("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipeline, together with the IF/ID pipeline register. It holds the program counter, drives the instruction-memory address, and captures the fetched word into IF/ID. It is the direct consumer of the hazard unit's stall output (`freeze`) and of the EXE-stage branch resolution. It also keeps a saturating count of frozen cycles for performance debug.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `freeze`  in  1  hazard-detected signal; holds PC and IF/ID.
- `branch_taken`  in  1  branch resolved taken in EXE.
- `branch_addr`  in  32  branch target.
- `imem_addr`  out  32  instruction-memory address; combinational, equal to `pc`.
- `imem_rdata`  in  32  instruction word; the memory returns it combinationally in the same cycle.
- `if_id_pc`  out  32  registered PC+4 of the captured instruction.
- `if_id_instr`  out  32  registered instruction word.
- `if_id_valid`  out  1  registered valid; 0 means a bubble.
- `stall_cnt`  out  CNT_W  number of frozen cycles since reset; saturating.

## Operation
- State consists of the `pc` register, the IF/ID register (`if_id_pc`, `if_id_instr`, `if_id_valid`) and `stall_cnt`.
- Each rising edge resolves its action by strict priority: `rst` > `branch_taken` > `freeze` > normal advance.
- rst:
  - `pc` <= RESET_PC.
  - `if_id_pc`, `if_id_instr` <= 0.
  - `if_id_valid` <= 0.
  - `stall_cnt` <= 0.
- branch_taken (no rst):
  - `pc` <= {branch_addr[31:2], 2'b00}; the low two bits are forced to 0.
  - IF/ID is flushed: `if_id_instr` <= 32'h0 (NOP), `if_id_pc` <= 0, `if_id_valid` <= 0.
  - `branch_taken` overrides `freeze` because the stalled instruction is squashed. `stall_cnt` does not increment in that cycle.
- freeze (no rst, no branch):
  - `pc` and every IF/ID field hold their values.
  - `stall_cnt` <= `stall_cnt` + 1, saturating at 2^CNT_W−1.
- normal advance:
  - `pc` <= `pc` + 4, modulo 2^32.
  - `if_id_pc` <= `pc` + 4.
  - `if_id_instr` <= `imem_rdata`.
  - `if_id_valid` <= 1.
- Arithmetic is 32-bit unsigned. PC 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- `imem_addr` is always `pc`, including during freeze; the memory read is simply repeated.
- When `rst` is asserted mid-stream, including during a freeze or together with `branch_taken`, all state returns to reset values on that edge.

## Timing
- One cycle of latency: the word at address A, presented while `pc`=A, appears on `if_id_instr` after the next edge, with `if_id_pc` = A+4.
- After `rst` deasserts, the first edge captures the instruction at RESET_PC. `if_id_valid` is therefore 1 from the second cycle after reset.
- `freeze`, `branch_taken` and `branch_addr` are sampled on the edge; the stage has no combinational path from them to any output.
- A taken branch produces exactly one bubble in IF/ID. The target instruction is captured on the following edge, provided that edge is not frozen.
- A freeze of N consecutive cycles stretches IF/ID by N cycles and adds N to `stall_cnt`.
- All outputs except `imem_addr` are registered.

## Test plan
- Reset, then sequential fetch: hold `rst`=1 for 2 cycles, release, memory returns A>>2 as data. Required: `pc` steps 0,4,8,12; `if_id_instr` is 0,1,2 on successive cycles; `if_id_pc` is 4,8,12; `if_id_valid` becomes 1 after the first edge.
- Freeze: at `pc`=8, assert `freeze` for 3 cycles. Required: `pc` stays 8; IF/ID holds instr 1 / pc 8; `stall_cnt`=3; fetch resumes with instr 2.
- Branch: at `pc`=12, pulse `branch_taken` with `branch_addr`=32'h0000_0103. Required: `pc`=32'h100; one bubble (`valid`=0, instr 0); then instr 32'h40 with `if_id_pc`=32'h104.
- Branch and freeze together: both asserted for one cycle, `branch_addr`=32'h200. Required: `pc`=32'h200, IF/ID flushed, `stall_cnt` unchanged.
- Wrap and reset mid-freeze: with `RESET_PC`=32'hFFFF_FFF8, run 3 cycles. Required: `pc` goes FFF8 → FFFC → 0. Then assert `freeze` and `rst` together. Required: `pc`=FFFF_FFF8, all IF/ID fields 0, `stall_cnt`=0.
- Saturation: with `CNT_W`=4, hold `freeze` for 20 cycles. Required: `stall_cnt` stops at 15.
